operand_bypass: RTL and testbench
=================================

// Module: operand_bypass
// PURPOSE
//  Read-side companion of the Beta register file. Drives the two file read addresses from
//  decode and tracks the three in-flight writes (EX, MEM, WB). Forwards the youngest pending
//  result over stale file data and stalls decode on load-use hazards. Delivers registered
//  operands to the EX stage, one cycle after issue.
// PARAMETERS
//  XLEN      32  datapath / operand width
//  RA_W      5   register address width
//  ZERO_REG  31  hard-wired zero register; never written, always reads 0
// PORTS
//  clk          in   1     system clock; all state updates on rising edge
//  rst_n        in   1     synchronous, active-low reset
//  id_valid     in   1     decode presents an instruction this cycle
//  id_ready     out  1     instruction accepted this cycle (comb)
//  id_ra1       in   RA_W  source register A
//  id_ra2       in   RA_W  source register B
//  id_dst       in   RA_W  destination register of issuing instruction
//  id_we        in   1     issuing instruction writes id_dst
//  id_is_load   in   1     issuing instruction is a load (data valid only in WB)
//  rf_ra1       out  RA_W  register file read address 1 (= id_ra1, comb)
//  rf_ra2       out  RA_W  register file read address 2 (= id_ra2, comb)
//  rf_rd1       in   XLEN  register file read data 1 (comb from file)
//  rf_rd2       in   XLEN  register file read data 2
//  ex_wd        in   XLEN  ALU result currently in EX
//  mem_wd       in   XLEN  result currently in MEM (ALU results only)
//  wb_wd        in   XLEN  result currently in WB (same value written to file this edge)
//  pipe_hold    in   1     downstream stall (e.g. memory wait); freezes this block
//  op_a         out  XLEN  registered operand A to EX
//  op_b         out  XLEN  registered operand B to EX
//  op_valid     out  1     op_a/op_b carry a real instruction (0 = bubble)
//  fwd_hits     out  2     debug: [0]=A forwarded, [1]=B forwarded (registered with ops)
// BEHAVIOUR
//  - Tracking: three records {vld, dst, is_load} for EX, MEM, WB; a record is vld only if id_we=1.
//    Each non-held cycle: WB<=MEM, MEM<=EX, EX<=issued record, or vld=0 on a bubble.
//  - Source resolve per operand, youngest first: ra==ZERO_REG -> 0, no hazard;
//    EX match -> ex_wd; MEM match -> mem_wd; WB match -> wb_wd; else rf_rdN.
//  - WB match is mandatory: the file writes at the same edge, so rf_rdN is stale that cycle.
//  - Load-use: EX record vld & is_load & dst matches a non-zero source -> hazard.
//    A MEM-stage load match is also a hazard (data not ready until WB).
//  - id_ready = !rst_n ? 0 : !pipe_hold & !(id_valid & hazard).
//  - Issue (id_valid & id_ready): op_a/op_b/fwd_hits load; op_valid<=1; EX record <= {id_we, id_dst, id_is_load}.
//  - Hazard cycle (not held): op_valid<=0, EX record vld<=0, MEM/WB advance; decode re-presents unchanged.
//  - pipe_hold=1 wins over everything: all records and outputs hold; id_ready=0.
//  - No id_valid and not held: bubble inserted exactly as in a hazard cycle.
//  - Reset (rst_n=0 at edge, incl. mid-stall): all records vld=0, op_a=op_b=0, op_valid=0, fwd_hits=0.
//  - Latency: issue at cycle N -> operands valid at EX in cycle N+1. Load-use costs 1-2 bubbles.
//  - Widths: no arithmetic; address compares are exact RA_W-bit equality.
// STRUCTURE
//  - Shared package beta_pkg: ZERO_REG, typedef wb_rec_t {vld, dst, is_load}.
//  - One natural sub-module: operand_fwd_mux, combinational resolve for one operand
//    (records + data buses -> value, hit, hazard); instantiated twice.
//  - Record pipeline, id_ready and output registers stay in the top.
// TESTING
//  1 reset: rst_n=0 two cycles with pipe_hold=0 -> op_valid=0, op_a=0, id_ready=0; release -> id_ready=1.
//  2 EX fwd: ADD r1<-.. then SUB ra1=r1, ex_wd=0x1234 -> op_a=0x1234, fwd_hits[0]=1.
//  3 priority: r2 in EX (0xAA) and WB (0xBB), read r2 -> op_b=0xAA; WB only, rf_rd2=0x0 -> op_b=0xBB.
//  4 load-use: LD r3 then ADD ra1=r3 -> id_ready=0 for 2 cycles, op_valid=0,0, then op_a=wb_wd.
//  5 zero reg: r31 as dst in EX and source ra1=31 -> op_a=0, no stall, fwd_hits[0]=0.
//  6 hold/reset: pipe_hold=1 for 3 cycles mid-stream -> outputs frozen; rst_n=0 during hold -> all cleared.

Source files
------------

// File: rtl/beta_pkg.sv
// Shared types and constants for the Beta read-side operand logic.
// A write-back record tracks one in-flight instruction that will write the register file.
package beta_pkg;

    localparam int              XLEN     = 32;
    localparam int              RA_W     = 5;
    localparam logic [RA_W-1:0] ZERO_REG = 5'd31;

    typedef struct packed {
        logic            vld;
        logic [RA_W-1:0] dst;
        logic            is_load;
    } wb_rec_t;

    // True when a live record targets the given source register.
    function automatic logic rec_match(input wb_rec_t rec, input logic [RA_W-1:0] ra);
        return rec.vld && (rec.dst == ra);
    endfunction

endpackage

// File: rtl/operand_fwd_mux.sv
// Combinational source resolve for one operand: picks the youngest pending result
// over the file data and flags a hazard when that result is a load still in flight.
module operand_fwd_mux
    import beta_pkg::*;
#(
    parameter int XLEN_P = XLEN
) (
    input  logic [RA_W-1:0]   i_ra,
    input  wb_rec_t           i_ex_rec,
    input  wb_rec_t           i_mem_rec,
    input  wb_rec_t           i_wb_rec,
    input  logic [XLEN_P-1:0] i_ex_wd,
    input  logic [XLEN_P-1:0] i_mem_wd,
    input  logic [XLEN_P-1:0] i_wb_wd,
    input  logic [XLEN_P-1:0] i_rf_rd,
    output logic [XLEN_P-1:0] o_val,
    output logic              o_hit,
    output logic              o_hazard
);

    // A load in WB already has its data on i_wb_wd, so its load flag is irrelevant here.
    logic w_unused_wb_ld;
    assign w_unused_wb_ld = i_wb_rec.is_load;

    // Priority resolve, youngest stage first; WB must win over the file because the
    // file write lands on the same edge and i_rf_rd is still stale this cycle.
    always_comb begin
        o_val    = i_rf_rd;
        o_hit    = 1'b0;
        o_hazard = 1'b0;
        if (i_ra == ZERO_REG) begin
            o_val    = {XLEN_P{1'b0}};
            o_hit    = 1'b0;
            o_hazard = 1'b0;
        end else if (rec_match(i_ex_rec, i_ra)) begin
            o_val    = i_ex_wd;
            o_hit    = 1'b1;
            o_hazard = i_ex_rec.is_load;
        end else if (rec_match(i_mem_rec, i_ra)) begin
            o_val    = i_mem_wd;
            o_hit    = 1'b1;
            o_hazard = i_mem_rec.is_load;
        end else if (rec_match(i_wb_rec, i_ra)) begin
            o_val    = i_wb_wd;
            o_hit    = 1'b1;
            o_hazard = 1'b0;
        end else begin
            o_val    = i_rf_rd;
            o_hit    = 1'b0;
            o_hazard = 1'b0;
        end
    end

endmodule

// File: rtl/operand_bypass.sv
// Read-side companion of the Beta register file: tracks EX/MEM/WB writes, forwards
// the youngest result, stalls decode on load-use and registers operands for EX.
module operand_bypass
    import beta_pkg::*;
#(
    parameter int XLEN_P = XLEN
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [RA_W-1:0]   id_ra1,
    input  logic [RA_W-1:0]   id_ra2,
    input  logic [RA_W-1:0]   id_dst,
    input  logic              id_we,
    input  logic              id_is_load,
    output logic [RA_W-1:0]   rf_ra1,
    output logic [RA_W-1:0]   rf_ra2,
    input  logic [XLEN_P-1:0] rf_rd1,
    input  logic [XLEN_P-1:0] rf_rd2,
    input  logic [XLEN_P-1:0] ex_wd,
    input  logic [XLEN_P-1:0] mem_wd,
    input  logic [XLEN_P-1:0] wb_wd,
    input  logic              pipe_hold,
    output logic [XLEN_P-1:0] op_a,
    output logic [XLEN_P-1:0] op_b,
    output logic              op_valid,
    output logic [1:0]        fwd_hits
);

    wb_rec_t           r_ex_rec;
    wb_rec_t           r_mem_rec;
    wb_rec_t           r_wb_rec;
    logic [XLEN_P-1:0] r_op_a;
    logic [XLEN_P-1:0] r_op_b;
    logic              r_op_valid;
    logic [1:0]        r_fwd_hits;

    logic [XLEN_P-1:0] w_val_a;
    logic [XLEN_P-1:0] w_val_b;
    logic              w_hit_a;
    logic              w_hit_b;
    logic              w_haz_a;
    logic              w_haz_b;
    logic              w_issue;

    assign rf_ra1 = id_ra1;
    assign rf_ra2 = id_ra2;

    operand_fwd_mux #(.XLEN_P(XLEN_P)) u_fwd_a (
        .i_ra      (id_ra1),
        .i_ex_rec  (r_ex_rec),
        .i_mem_rec (r_mem_rec),
        .i_wb_rec  (r_wb_rec),
        .i_ex_wd   (ex_wd),
        .i_mem_wd  (mem_wd),
        .i_wb_wd   (wb_wd),
        .i_rf_rd   (rf_rd1),
        .o_val     (w_val_a),
        .o_hit     (w_hit_a),
        .o_hazard  (w_haz_a)
    );

    operand_fwd_mux #(.XLEN_P(XLEN_P)) u_fwd_b (
        .i_ra      (id_ra2),
        .i_ex_rec  (r_ex_rec),
        .i_mem_rec (r_mem_rec),
        .i_wb_rec  (r_wb_rec),
        .i_ex_wd   (ex_wd),
        .i_mem_wd  (mem_wd),
        .i_wb_wd   (wb_wd),
        .i_rf_rd   (rf_rd2),
        .o_val     (w_val_b),
        .o_hit     (w_hit_b),
        .o_hazard  (w_haz_b)
    );

    assign id_ready = rst_n & ~pipe_hold & ~(id_valid & (w_haz_a | w_haz_b));
    assign w_issue  = id_valid & id_ready;

    // Record pipeline and EX operand registers; hold freezes everything, a
    // non-issuing cycle pushes a bubble while older records keep draining.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ex_rec   <= '0;
            r_mem_rec  <= '0;
            r_wb_rec   <= '0;
            r_op_a     <= {XLEN_P{1'b0}};
            r_op_b     <= {XLEN_P{1'b0}};
            r_op_valid <= 1'b0;
            r_fwd_hits <= 2'b00;
        end else if (pipe_hold) begin
            r_ex_rec   <= r_ex_rec;
            r_mem_rec  <= r_mem_rec;
            r_wb_rec   <= r_wb_rec;
            r_op_valid <= r_op_valid;
        end else begin
            r_wb_rec  <= r_mem_rec;
            r_mem_rec <= r_ex_rec;
            if (w_issue) begin
                r_ex_rec   <= '{vld: id_we, dst: id_dst, is_load: id_is_load};
                r_op_a     <= w_val_a;
                r_op_b     <= w_val_b;
                r_fwd_hits <= {w_hit_b, w_hit_a};
                r_op_valid <= 1'b1;
            end else begin
                r_ex_rec.vld <= 1'b0;
                r_op_valid   <= 1'b0;
            end
        end
    end

    assign op_a     = r_op_a;
    assign op_b     = r_op_b;
    assign op_valid = r_op_valid;
    assign fwd_hits = r_fwd_hits;

endmodule

// File: tb/tb_operand_bypass.sv
// Directed bench for operand_bypass: a table of per-cycle vectors with hand-computed
// results, plus hand sequences for reset and reset-during-hold.
module tb_operand_bypass;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic        id_ready;
    logic [4:0]  id_ra1, id_ra2, id_dst;
    logic        id_we, id_is_load;
    logic [4:0]  rf_ra1, rf_ra2;
    logic [31:0] rf_rd1, rf_rd2, ex_wd, mem_wd, wb_wd;
    logic        pipe_hold;
    logic [31:0] op_a, op_b;
    logic        op_valid;
    logic [1:0]  fwd_hits;

    int n_chk = 0;
    int n_err = 0;

    operand_bypass dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .id_valid   (id_valid),
        .id_ready   (id_ready),
        .id_ra1     (id_ra1),
        .id_ra2     (id_ra2),
        .id_dst     (id_dst),
        .id_we      (id_we),
        .id_is_load (id_is_load),
        .rf_ra1     (rf_ra1),
        .rf_ra2     (rf_ra2),
        .rf_rd1     (rf_rd1),
        .rf_rd2     (rf_rd2),
        .ex_wd      (ex_wd),
        .mem_wd     (mem_wd),
        .wb_wd      (wb_wd),
        .pipe_hold  (pipe_hold),
        .op_a       (op_a),
        .op_b       (op_b),
        .op_valid   (op_valid),
        .fwd_hits   (fwd_hits)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        vld;
        logic [4:0]  ra1, ra2, dst;
        logic        we, ld, hold;
        logic [31:0] rd1, rd2, exw, memw, wbw;
        logic        e_rdy, e_ov;
        logic [31:0] e_a, e_b;
        logic [1:0]  e_h;
    } vec_t;

    function automatic vec_t mk(
        input logic vld, input logic [4:0] ra1, input logic [4:0] ra2, input logic [4:0] dst,
        input logic we, input logic ld, input logic hold,
        input logic [31:0] rd1, input logic [31:0] rd2, input logic [31:0] exw,
        input logic [31:0] memw, input logic [31:0] wbw,
        input logic e_rdy, input logic e_ov, input logic [31:0] e_a, input logic [31:0] e_b,
        input logic [1:0] e_h);
        vec_t v;
        v.vld = vld; v.ra1 = ra1; v.ra2 = ra2; v.dst = dst; v.we = we; v.ld = ld; v.hold = hold;
        v.rd1 = rd1; v.rd2 = rd2; v.exw = exw; v.memw = memw; v.wbw = wbw;
        v.e_rdy = e_rdy; v.e_ov = e_ov; v.e_a = e_a; v.e_b = e_b; v.e_h = e_h;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        id_valid = v.vld; id_ra1 = v.ra1; id_ra2 = v.ra2; id_dst = v.dst;
        id_we = v.we; id_is_load = v.ld; pipe_hold = v.hold;
        rf_rd1 = v.rd1; rf_rd2 = v.rd2; ex_wd = v.exw; mem_wd = v.memw; wb_wd = v.wbw;
    endtask

    vec_t vt[19];
    vec_t vr;

    initial begin
        vt[0]  = mk(1'b1, 5'd4,  5'd5,  5'd1,  1'b1, 1'b0, 1'b0, 32'h11, 32'h22, 32'h0, 32'h0, 32'h0,
                    1'b1, 1'b1, 32'h11, 32'h22, 2'b00);
        vt[1]  = mk(1'b1, 5'd1,  5'd6,  5'd7,  1'b1, 1'b0, 1'b0, 32'hDEAD, 32'h66, 32'h1234, 32'h0, 32'h0,
                    1'b1, 1'b1, 32'h1234, 32'h66, 2'b01);
        vt[2]  = mk(1'b1, 5'd0,  5'd0,  5'd2,  1'b1, 1'b0, 1'b0, 32'h5, 32'h6, 32'h0, 32'h0, 32'h0,
                    1'b1, 1'b1, 32'h5, 32'h6, 2'b00);
        vt[3]  = mk(1'b1, 5'd10, 5'd11, 5'd9,  1'b1, 1'b0, 1'b0, 32'h1, 32'h2, 32'h0, 32'h0, 32'h0,
                    1'b1, 1'b1, 32'h1, 32'h2, 2'b00);
        vt[4]  = mk(1'b1, 5'd12, 5'd13, 5'd2,  1'b1, 1'b0, 1'b0, 32'h3, 32'h4, 32'h0, 32'h0, 32'h0,
                    1'b1, 1'b1, 32'h3, 32'h4, 2'b00);
        // r2 live in EX and WB: EX must win
        vt[5]  = mk(1'b1, 5'd14, 5'd2,  5'd20, 1'b1, 1'b0, 1'b0, 32'h77, 32'h0, 32'hAA, 32'hCC, 32'hBB,
                    1'b1, 1'b1, 32'h77, 32'hAA, 2'b10);
        vt[6]  = mk(1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                    1'b1, 1'b0, 32'h77, 32'hAA, 2'b10);
        // r2 only in WB, file still reads 0
        vt[7]  = mk(1'b1, 5'd15, 5'd2,  5'd0,  1'b0, 1'b0, 1'b0, 32'h88, 32'h0, 32'hAA, 32'hCC, 32'hBB,
                    1'b1, 1'b1, 32'h88, 32'hBB, 2'b10);
        // load r3 then use: two bubbles, then WB forward
        vt[8]  = mk(1'b1, 5'd16, 5'd17, 5'd3,  1'b1, 1'b1, 1'b0, 32'h10, 32'h20, 32'h0, 32'h0, 32'h0,
                    1'b1, 1'b1, 32'h10, 32'h20, 2'b00);
        vt[9]  = mk(1'b1, 5'd3,  5'd18, 5'd4,  1'b1, 1'b0, 1'b0, 32'h999, 32'h30, 32'hE1, 32'hE2, 32'hE3,
                    1'b0, 1'b0, 32'h10, 32'h20, 2'b00);
        vt[10] = mk(1'b1, 5'd3,  5'd18, 5'd4,  1'b1, 1'b0, 1'b0, 32'h999, 32'h30, 32'hE1, 32'hE2, 32'hE3,
                    1'b0, 1'b0, 32'h10, 32'h20, 2'b00);
        vt[11] = mk(1'b1, 5'd3,  5'd18, 5'd4,  1'b1, 1'b0, 1'b0, 32'h999, 32'h30, 32'hE1, 32'hE2, 32'h5A5A,
                    1'b1, 1'b1, 32'h5A5A, 32'h30, 2'b01);
        vt[12] = mk(1'b1, 5'd0,  5'd0,  5'd5,  1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                    1'b1, 1'b1, 32'h0, 32'h0, 2'b00);
        // MEM and EX forward together; issue a load into r31
        vt[13] = mk(1'b1, 5'd4,  5'd5,  5'd31, 1'b1, 1'b1, 1'b0, 32'h1, 32'h1, 32'hE5, 32'hE4, 32'h0,
                    1'b1, 1'b1, 32'hE4, 32'hE5, 2'b11);
        // zero register read while r31 load in EX: no stall, reads 0
        vt[14] = mk(1'b1, 5'd31, 5'd4,  5'd6,  1'b1, 1'b0, 1'b0, 32'hFFFFFFFF, 32'h1, 32'h77, 32'h55, 32'h44,
                    1'b1, 1'b1, 32'h0, 32'h44, 2'b10);
        for (int i = 15; i < 18; i++)
            vt[i] = mk(1'b1, 5'd6, 5'd31, 5'd0, 1'b0, 1'b0, 1'b1, 32'h1, 32'h2, 32'h66, 32'h0, 32'h0,
                       1'b0, 1'b1, 32'h0, 32'h44, 2'b10);
        vt[18] = mk(1'b1, 5'd6,  5'd31, 5'd0,  1'b0, 1'b0, 1'b0, 32'h1, 32'h2, 32'h66, 32'h0, 32'h0,
                    1'b1, 1'b1, 32'h66, 32'h0, 2'b01);

        // reset with a would-be issue on the inputs
        rst_n = 1'b0;
        drive(mk(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 32'h9, 32'h9, 32'h9, 32'h9, 32'h9,
                 1'b0, 1'b0, 32'h0, 32'h0, 2'b00));
        repeat (2) begin
            @(posedge clk); #1;
            chk("rst_ready", {31'd0, id_ready}, 32'd0);
            chk("rst_op_valid", {31'd0, op_valid}, 32'd0);
            chk("rst_op_a", op_a, 32'd0);
            chk("rst_op_b", op_b, 32'd0);
            chk("rst_hits", {30'd0, fwd_hits}, 32'd0);
        end
        id_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("release_ready", {31'd0, id_ready}, 32'd1);

        for (int i = 0; i < 19; i++) begin
            drive(vt[i]);
            #1;
            chk($sformatf("v%0d_ready", i), {31'd0, id_ready}, {31'd0, vt[i].e_rdy});
            chk($sformatf("v%0d_rf_ra1", i), {27'd0, rf_ra1}, {27'd0, vt[i].ra1});
            chk($sformatf("v%0d_rf_ra2", i), {27'd0, rf_ra2}, {27'd0, vt[i].ra2});
            @(posedge clk); #1;
            chk($sformatf("v%0d_op_valid", i), {31'd0, op_valid}, {31'd0, vt[i].e_ov});
            chk($sformatf("v%0d_op_a", i), op_a, vt[i].e_a);
            chk($sformatf("v%0d_op_b", i), op_b, vt[i].e_b);
            chk($sformatf("v%0d_hits", i), {30'd0, fwd_hits}, {30'd0, vt[i].e_h});
        end

        // reset asserted while held must still clear everything
        rst_n = 1'b0;
        pipe_hold = 1'b1;
        id_valid = 1'b1;
        #1;
        chk("hrst_ready", {31'd0, id_ready}, 32'd0);
        @(posedge clk); #1;
        chk("hrst_op_valid", {31'd0, op_valid}, 32'd0);
        chk("hrst_op_a", op_a, 32'd0);
        chk("hrst_op_b", op_b, 32'd0);
        chk("hrst_hits", {30'd0, fwd_hits}, 32'd0);

        // records cleared: r6 must now come from the file
        rst_n = 1'b1;
        vr = mk(1'b1, 5'd6, 5'd31, 5'd0, 1'b0, 1'b0, 1'b0, 32'h12340000, 32'h2, 32'h66, 32'h77, 32'h88,
                1'b1, 1'b1, 32'h12340000, 32'h0, 2'b00);
        drive(vr);
        #1;
        chk("post_ready", {31'd0, id_ready}, {31'd0, vr.e_rdy});
        @(posedge clk); #1;
        chk("post_op_valid", {31'd0, op_valid}, {31'd0, vr.e_ov});
        chk("post_op_a", op_a, vr.e_a);
        chk("post_op_b", op_b, vr.e_b);
        chk("post_hits", {30'd0, fwd_hits}, {30'd0, vr.e_h});

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
